packer_chain_arbiter: RTL and testbench

Round-robin arbiter sharing one dataPacker input between NUM_REQ trace requesters. Each requester presents N-wide vectors with a chain id and an end-of-frame flag. The arbiter locks a grant for a whole frame (until eof) or until MAX_BURST beats, whichever comes first. It drives the packer's valid_in / eof_in / chainId_in / vector_in from a registered output stage.

---
 rtl/packer_chain_arbiter.sv | 110 +++++++++++
 tb/tb_packer_chain_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packer_chain_arbiter.sv
// rtl/packer_chain_arbiter.sv - round-robin, frame-locked arbiter feeding one dataPacker input
module packer_chain_arbiter #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16,
    localparam int GW        = $clog2(NUM_REQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tracing,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_eof,
    input  logic [NUM_REQ-1:0]             req_chainId,
    input  logic [NUM_REQ*N*DATA_WIDTH-1:0] req_vector,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           valid_out,
    output logic                           eof_out,
    output logic                           chainId_out,
    output logic [DATA_WIDTH-1:0]          vector_out [N],
    output logic [GW-1:0]                  grant_out
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   rr_ptr;
    logic [CW-1:0]   beat_cnt;
    logic [GW-1:0]   pick_hi;
    logic [GW-1:0]   pick_any;
    logic            hit_hi;
    logic [GW-1:0]   next_grant;
    logic [GW-1:0]   next_ptr;
    logic            xfer;
    logic            last_beat;
    logic [DATA_WIDTH-1:0] lanes [NUM_REQ][N];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        for (genvar i = 0; i < N; i++) begin : g_lane
            assign lanes[r][i] = req_vector[(r*N+i)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        pick_hi  = '0;
        pick_any = '0;
        hit_hi   = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                pick_any = GW'(i);
                if (GW'(i) >= rr_ptr) begin
                    pick_hi = GW'(i);
                    hit_hi  = 1'b1;
                end
            end
        end
        next_grant = hit_hi ? pick_hi : pick_any;
    end

    assign next_ptr  = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
    assign xfer      = (state == BURST) && tracing && req_valid[grant];
    assign last_beat = req_eof[grant] || (beat_cnt == CW'(MAX_BURST - 1));
    assign grant_out = grant;

    always_comb begin
        req_ready = '0;
        if (state == BURST) req_ready[grant] = tracing;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
            chainId_out <= 1'b0;
            for (int i = 0; i < N; i++) vector_out[i] <= '0;
        end else begin
            valid_out <= xfer;
            case (state)
                IDLE: begin
                    if (tracing && |req_valid) begin
                        grant    <= next_grant;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        eof_out     <= req_eof[grant];
                        chainId_out <= req_chainId[grant];
                        for (int i = 0; i < N; i++) vector_out[i] <= lanes[grant][i];
                        beat_cnt    <= beat_cnt + CW'(1);
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packer_chain_arbiter.sv
// tb/tb_packer_chain_arbiter.sv - self-checking bench for packer_chain_arbiter
module tb_packer_chain_arbiter;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int VW = N * DW;

    typedef struct packed {
        logic [VW-1:0] vec;
        logic          eof;
        logic          chain;
    } beat_t;

    typedef struct packed {
        beat_t      b;
        logic [1:0] g;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tracing;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_eof;
    logic [NR-1:0]    req_chainId;
    logic [NR*VW-1:0] req_vector;
    logic [NR-1:0]    req_ready;
    logic             valid_out;
    logic             eof_out;
    logic             chainId_out;
    logic [DW-1:0]    vector_out [N];
    logic [1:0]       grant_out;

    beat_t q [NR][$];
    exp_t  expq [$];
    int    m_ptr;
    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc;
    int    last_v;
    logic [31:0] vpat, epat, gseq;
    bit    trace_en;
    bit    rnd_trace;

    packer_chain_arbiter #(.N(N), .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .tracing(tracing),
        .req_valid(req_valid), .req_eof(req_eof), .req_chainId(req_chainId),
        .req_vector(req_vector), .req_ready(req_ready),
        .valid_out(valid_out), .eof_out(eof_out), .chainId_out(chainId_out),
        .vector_out(vector_out), .grant_out(grant_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack_vo();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = vector_out[i];
        return v;
    endfunction

    function automatic beat_t mk(input logic [31:0] l0, input logic e, input logic c);
        beat_t b;
        for (int i = 0; i < N; i++) b.vec[i*DW +: DW] = $urandom;
        b.vec[31:0] = l0;
        b.eof   = e;
        b.chain = c;
        return b;
    endfunction

    // Reference: walk the queued frames in round-robin order, one grant per frame or per MB beats.
    function automatic void build();
        beat_t lq [NR][$];
        beat_t b;
        exp_t  e;
        int    g, cnt;
        bit    found;
        for (int r = 0; r < NR; r++) lq[r] = q[r];
        while (1) begin
            found = 0;
            g = 0;
            for (int k = 0; k < NR; k++) begin
                if (!found && lq[(m_ptr + k) % NR].size() > 0) begin
                    found = 1;
                    g = (m_ptr + k) % NR;
                end
            end
            if (!found) break;
            cnt = 0;
            do begin
                b = lq[g].pop_front();
                e.b = b;
                e.g = 2'(g);
                expq.push_back(e);
                cnt++;
            end while (!b.eof && cnt < MB && lq[g].size() > 0);
            m_ptr = (g + 1) % NR;
        end
    endfunction

    task automatic drive();
        tracing = trace_en && (!rnd_trace || ($urandom_range(0, 3) != 0));
        for (int r = 0; r < NR; r++) begin
            if (q[r].size() > 0) begin
                req_valid[r]            = 1'b1;
                req_eof[r]              = q[r][0].eof;
                req_chainId[r]          = q[r][0].chain;
                req_vector[r*VW +: VW]  = q[r][0].vec;
            end else begin
                req_valid[r] = 1'b0;
                req_eof[r]   = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        logic [NR-1:0] acc;
        int            r;
        exp_t          e;
        @(negedge clk);
        acc = req_valid & req_ready;
        chk("ready_onehot", VW'($onehot0(req_ready)), 1);
        if (!tracing) chk("ready_no_trace", req_ready, 0);
        @(posedge clk);
        #1;
        cyc++;
        chk("valid_timing", valid_out, VW'(acc != 0));
        vpat = {vpat[30:0], valid_out};
        epat = {epat[30:0], eof_out & valid_out};
        if (acc != 0) begin
            r = 0;
            for (int i = 0; i < NR; i++) if (acc[i]) r = i;
            if (expq.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("grant_order", VW'(r), VW'(e.g));
                chk("grant_out", grant_out, e.g);
                chk("vector", pack_vo(), e.b.vec);
                chk("eof", eof_out, e.b.eof);
                chk("chain", chainId_out, e.b.chain);
            end
            void'(q[r].pop_front());
            gseq   = {gseq[29:0], grant_out};
            last_v = cyc;
        end
        drive();
    endtask

    task automatic start();
        build();
        cyc = 0; last_v = 0; vpat = '0; epat = '0; gseq = '0;
        drive();
    endtask

    task automatic run(input int maxc);
        int c = 0;
        while (expq.size() > 0 && c < maxc) begin
            cycle();
            c++;
        end
        chk("drained", VW'(expq.size()), 0);
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        trace_en = 0; rnd_trace = 0;
        for (int r = 0; r < NR; r++) q[r].delete();
        expq.delete();
        m_ptr = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_grant", grant_out, 0);
        chk("rst_vector", pack_vo(), 0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        trace_en = 1;
        drive();
    endtask

    initial begin
        req_valid = '0; req_eof = '0; req_chainId = '0; req_vector = '0;
        tracing = 1'b0;

        // Single 3-beat frame on requester 2, then check the pointer moved past it.
        do_reset();
        q[2].push_back(mk(1, 0, 0));
        q[2].push_back(mk(2, 0, 0));
        q[2].push_back(mk(3, 1, 0));
        start();
        run(20);
        chk("t1_valid_pat", vpat[5:0], 6'b011100);
        chk("t1_eof_pat", epat[5:0], 6'b000100);
        q[0].push_back(mk(10, 1, 0));
        q[3].push_back(mk(11, 1, 0));
        start();
        run(20);
        chk("t1_rr_ptr", gseq[3:0], 4'b1100);

        // chainId and lane mapping on requester 3.
        do_reset();
        begin
            beat_t b;
            for (int i = 0; i < N; i++) b.vec[i*DW +: DW] = 32'h100 + i;
            b.eof = 1; b.chain = 1;
            q[3].push_back(b);
        end
        start();
        repeat (2) cycle();
        chk("t6_chain", chainId_out, 1);
        chk("t6_grant", grant_out, 3);
        for (int i = 0; i < N; i++) chk("t6_lane", vector_out[i], VW'(32'h100 + i));
        run(10);

        // Asynchronous reset mid-burst, then round-robin over all requesters from 0.
        do_reset();
        for (int i = 0; i < 6; i++) q[1].push_back(mk(i, i == 5, 0));
        start();
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", valid_out, 0);
        chk("t5_async_grant", grant_out, 0);
        chk("t5_async_vector", pack_vo(), 0);
        chk("t5_async_ready", req_ready, 0);
        for (int r = 0; r < NR; r++) q[r].delete();
        expq.delete();
        m_ptr = 0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        q[0].push_back(mk(20, 1, 0));
        q[0].push_back(mk(24, 1, 1));
        q[1].push_back(mk(21, 1, 0));
        q[2].push_back(mk(22, 1, 1));
        q[3].push_back(mk(23, 1, 0));
        start();
        run(40);
        chk("t2_grant_seq", gseq[9:0], 10'b00_01_10_11_00);
        chk("t2_bubbles", vpat[11:0], 12'b010101010100);

        // Forced release after MB beats while another requester waits.
        do_reset();
        for (int i = 0; i < 10; i++) q[0].push_back(mk(i, i == 9, 0));
        q[1].push_back(mk(100, 0, 1));
        q[1].push_back(mk(101, 1, 1));
        start();
        run(60);
        chk("t3_grant_seq", gseq[23:0], 24'h005000);

        // Tracing gap of 3 cycles inside a 4-beat frame.
        do_reset();
        for (int i = 0; i < 4; i++) q[1].push_back(mk(i, i == 3, 0));
        start();
        repeat (3) cycle();
        trace_en = 0;
        drive();
        repeat (3) begin
            cycle();
            chk("t4_gap_valid", valid_out, 0);
        end
        trace_en = 1;
        drive();
        run(20);
        chk("t4_last_beat_cycle", VW'(last_v), 8);

        // Randomized frames with random tracing.
        for (int round = 0; round < 4; round++) begin
            do_reset();
            rnd_trace = 1;
            for (int r = 0; r < NR; r++) begin
                int nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) begin
                    int  len = $urandom_range(1, 7);
                    logic c  = 1'($urandom);
                    for (int j = 0; j < len; j++) q[r].push_back(mk($urandom, j == len - 1, c));
                end
            end
            start();
            run(2000);
            rnd_trace = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
